mod_counter: RTL and testbench
==============================

// Module: mod_counter
// PURPOSE
//  Parametrised modulo up/down counter: the next generation of the single-bit DFF stage.
//  WIDTH-bit state register with enable, direction, synchronous load/clear and an optional prescaler.
//  Carry/borrow outputs allow cascading: chain stages for BCD/clock-display digits.
//  Sits between the board clock and display/LED logic in the counter labs.
// PARAMETERS
//  WIDTH     8   counter width in bits; legal range is 1..32.
//  MODULUS  10   count range 0..MODULUS-1; legal range is 2..2**WIDTH.
//  PRESCALE  1   clk cycles per count step; 1 = count every enabled cycle; legal range is 1..2**24.
//  INIT      0   value of q after reset; must be < MODULUS.
// PORTS
//  clk       in   1      rising-edge clock; the only clock.
//  rst       in   1      asynchronous, active-low reset.
//  en        in   1      count enable; also gates the prescaler.
//  up        in   1      1 = increment, 0 = decrement.
//  clr       in   1      synchronous clear to 0; highest synchronous priority.
//  load      in   1      synchronous load of load_val.
//  load_val  in   WIDTH  load data.
//  q         out  WIDTH  registered count value.
//  tc        out  1      combinational terminal count, used as en for the next cascaded stage.
//  wrap      out  1      registered 1-cycle pulse, one cycle after q wraps in either direction.
// BEHAVIOUR
//  - Reset (rst=0, any time, independent of clk): q=INIT, wrap=0, prescaler count=0.
//    Release is synchronous to the next clk edge; mid-operation reset discards all state.
//  - Synchronous priority per rising edge: clr > load > count > hold.
//  - clr=1: q<=0, prescaler<=0, wrap<=0.
//  - load=1 (clr=0): q<=load_val, prescaler<=0, wrap<=0.
//    If load_val>=MODULUS, q<=MODULUS-1 (saturating clamp).
//  - Prescaler: pcnt runs 0..PRESCALE-1 while en=1 and holds while en=0. tick = en & (pcnt==PRESCALE-1).
//    With PRESCALE=1, tick=en and no pcnt register is generated.
//  - Count on tick (clr=0, load=0):
//    - up=1:  q==MODULUS-1 -> q<=0, wrap<=1; else q<=q+1.
//    - up=0:  q==0 -> q<=MODULUS-1, wrap<=1; else q<=q-1.
//  - Any edge without a wrap: wrap<=0. wrap is therefore never high two cycles in a row unless q wraps every cycle.
//  - tc = tick & ~clr & ~load & (up ? q==MODULUS-1 : q==0). It is high in the same cycle as the edge that wraps q,
//    so cascaded stage n+1 (en tied to tc of stage n, same clk, PRESCALE=1) steps on the same edge.
//  - up may change on any cycle; the new direction applies at the next tick. No glitch on q.
//  - Arithmetic is unsigned WIDTH bits and never exceeds MODULUS-1.
//    When MODULUS==2**WIDTH, wrap comes from natural overflow and the compare still holds.
//  - Latency: q updates one clk after the qualifying tick; wrap is aligned with that q update; tc is combinational.
// STRUCTURE
//  - Shared header mod_counter_defs.vh:
//    - PRIO_* localparams for the clr/load/count priority encoding.
//    - Function clog2 for sizing pcnt.
//  - Sub-module clk_en_div (PRESCALE; ports clk, rst, en, clr, tick):
//    - Holds the prescaler.
//    - Reused by other lab blocks needing slow enables.
//    - The clock is never divided: gated-enable only.
//  - Top body: priority mux, modulo next-state logic, wrap register, tc decode.
// TESTING
//  - Testbench mod_counter_test, STEP=1000 ns clock. Dump mod_counter.vcd and $monitor all ports.
//  - T1 reset: rst=0 at t=250 ns mid-cycle, INIT=3 -> q=3, wrap=0 immediately, without waiting for clk; hold 2 cycles.
//  - T2 up-wrap: MODULUS=10, en=1, up=1, 12 edges from 0 -> q 1..9,0,1,2.
//    tc=1 only while q=9; wrap=1 exactly in the cycle q shows 0.
//  - T3 down-wrap: from q=1, up=0, 3 edges -> q 0,9,8; wrap=1 in the cycle q=9.
//  - T4 priority/clamp: clr=1 & load=1 with load_val=5 -> q=0.
//    Then load=1, load_val=12 (MODULUS=10) -> q=9.
//    Then en=0 for 5 cycles -> q stays 9, tc=0.
//  - T5 prescaler: PRESCALE=4, en=1 -> q steps once per 4 edges.
//    Drop en for 2 cycles mid-period -> step delayed by exactly 2 edges.
//    load mid-period restarts the 4-cycle count.
//  - T6 cascade: two instances, MODULUS=10, en1=tc0 -> after 100 edges from 00, {q1,q0}=00;
//    q1 increments on the same edge q0 goes 9->0.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo counter and its enable divider.
// The priority encoding makes the clr > load > count > hold order explicit in one place.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        PRIO_HOLD  = 2'd0,
        PRIO_COUNT = 2'd1,
        PRIO_LOAD  = 2'd2,
        PRIO_CLR   = 2'd3
    } prio_e;

    // Ceiling log2; sizes the prescaler counter (value >= 2 yields >= 1 bit).
    function automatic int clog2(input longint unsigned value);
        int result;
        result = 0;
        while ((64'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_counter_clk_en_div.sv
// Gated-enable prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// The clock itself is never divided, so downstream logic stays on clk.
module mod_counter_clk_en_div
    import mod_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_direct
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, clr};
            assign tick = en;
        end else begin : g_div
            localparam int PW = clog2(64'(PRESCALE));
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pcnt_q;
            logic [PW-1:0] pcnt_d;

            // Holds while en is low, so a paused enable delays the tick cycle-for-cycle.
            always_comb begin
                pcnt_d = pcnt_q;
                if (clr) begin
                    pcnt_d = '0;
                end else if (en) begin
                    pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + PW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pcnt_q <= '0;
                end else begin
                    pcnt_q <= pcnt_d;
                end
            end

            assign tick = en & (pcnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load/clear, prescaled enable and cascade outputs.
// tc is combinational so a chained stage steps on the same edge this stage wraps.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 10,
    parameter int unsigned     PRESCALE = 1,
    parameter longint unsigned INIT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam int              WP1      = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
    localparam logic [WP1-1:0]  MOD_EXT  = WP1'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             tick;
    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    prio_e            sel;

    // Prescaler restarts its period on either clear or load.
    mod_counter_clk_en_div #(
        .PRESCALE (PRESCALE)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr | load),
        .tick (tick)
    );

    assign at_top  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    // Compare one bit wider so MODULUS == 2**WIDTH never clamps.
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

    always_comb begin
        if (clr) begin
            sel = PRIO_CLR;
        end else if (load) begin
            sel = PRIO_LOAD;
        end else if (tick) begin
            sel = PRIO_COUNT;
        end else begin
            sel = PRIO_HOLD;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        case (sel)
            PRIO_CLR: begin
                count_d = '0;
            end
            PRIO_LOAD: begin
                count_d = load_clamped;
            end
            PRIO_COUNT: begin
                if (up) begin
                    count_d = at_top ? '0 : count_q + WIDTH'(1);
                    wrap_d  = at_top;
                end else begin
                    count_d = at_zero ? MAX_VAL : count_q - WIDTH'(1);
                    wrap_d  = at_zero;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= INIT_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign tc   = (sel == PRIO_COUNT) & (up ? at_top : at_zero);
    assign q    = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: directed stimulus pushes expected q/wrap per edge,
// popped and compared one time unit after the edge.
`timescale 1ns/1ps
module tb_mod_counter;

    typedef struct {
        logic [7:0] q;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WIDTH 8, MODULUS 10, PRESCALE 1, INIT 3
    logic       a_en = 0, a_up = 0, a_clr = 0, a_load = 0;
    logic [7:0] a_lv = '0, a_q;
    logic       a_tc, a_wrap;

    // Prescaled instance: PRESCALE 4
    logic       p_en = 0, p_up = 0, p_clr = 0, p_load = 0;
    logic [7:0] p_lv = '0, p_q;
    logic       p_tc, p_wrap;

    // Full-range instance: WIDTH 4, MODULUS 16, INIT 5
    logic       f_en = 0, f_up = 0, f_clr = 0, f_load = 0;
    logic [3:0] f_lv = '0, f_q;
    logic       f_tc, f_wrap;

    // Two-digit cascade
    logic       c_en = 0, c_up = 1, c_clr = 0, c_load = 0;
    logic [3:0] c_lv = '0, c0_q, c1_q;
    logic       c0_tc, c0_wrap, c1_tc, c1_wrap;

    mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .INIT(3)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .up(a_up), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .q(a_q), .tc(a_tc), .wrap(a_wrap));

    mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(4), .INIT(0)) dut_p (
        .clk(clk), .rst(rst), .en(p_en), .up(p_up), .clr(p_clr), .load(p_load),
        .load_val(p_lv), .q(p_q), .tc(p_tc), .wrap(p_wrap));

    mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .INIT(5)) dut_f (
        .clk(clk), .rst(rst), .en(f_en), .up(f_up), .clr(f_clr), .load(f_load),
        .load_val(f_lv), .q(f_q), .tc(f_tc), .wrap(f_wrap));

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .INIT(0)) dut_c0 (
        .clk(clk), .rst(rst), .en(c_en), .up(c_up), .clr(c_clr), .load(c_load),
        .load_val(c_lv), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap));

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .INIT(0)) dut_c1 (
        .clk(clk), .rst(rst), .en(c0_tc), .up(c_up), .clr(c_clr), .load(c_load),
        .load_val(c_lv), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap));

    task automatic push_exp(input logic [7:0] q, input logic w);
        exp_t e;
        e.q    = q;
        e.wrap = w;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        $display("reset_init a_q=%0d a_wrap=%0b p_q=%0d f_q=%0d", a_q, a_wrap, p_q, f_q);
        if (a_q !== 8'd3 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_a q=%0d wrap=%0b expected q=3 wrap=0", a_q, a_wrap);
        end
        checks++;
        if (p_q !== 8'd0 || p_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_p q=%0d wrap=%0b expected q=0 wrap=0", p_q, p_wrap);
        end
        checks++;
        if (f_q !== 4'd5) begin
            errors++;
            $display("FAIL reset_init_f q=%0d expected 5", f_q);
        end
        rst    = 1'b1;
        a_load = 1'b1;
        a_lv   = 8'd7;
        push_exp(8'd7, 1'b0);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL reset_load scoreboard empty");
        end else begin
            e = sb.pop_front();
            checks++;
            $display("reset_load q=%0d wrap=%0b", a_q, a_wrap);
            if (a_q !== e.q || a_wrap !== e.wrap) begin
                errors++;
                $display("FAIL reset_load q=%0d wrap=%0b expected q=%0d wrap=%0b", a_q, a_wrap, e.q, e.wrap);
            end
        end
        a_load = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        $display("reset_async q=%0d wrap=%0b", a_q, a_wrap);
        if (a_q !== 8'd3 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_async q=%0d wrap=%0b expected q=3 wrap=0", a_q, a_wrap);
        end
        a_en = 1'b1;
        a_up = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            $display("reset_hold q=%0d", a_q);
            if (a_q !== 8'd3) begin
                errors++;
                $display("FAIL reset_hold q=%0d expected 3", a_q);
            end
        end
        rst  = 1'b1;
        a_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_q !== 8'd3 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_release q=%0d wrap=%0b expected q=3 wrap=0", a_q, a_wrap);
        end
    endtask

    task automatic test_up_wrap();
        exp_t e;
        int   cur;
        int   nxt;
        a_clr = 1'b1;
        push_exp(8'd0, 1'b0);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL up_clr scoreboard empty");
        end else begin
            e = sb.pop_front();
            checks++;
            if (a_q !== e.q || a_wrap !== e.wrap) begin
                errors++;
                $display("FAIL up_clr q=%0d wrap=%0b expected q=%0d wrap=%0b", a_q, a_wrap, e.q, e.wrap);
            end
        end
        a_clr = 1'b0;
        a_en  = 1'b1;
        a_up  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cur = i % 10;
            nxt = (i + 1) % 10;
            #1;
            checks++;
            if (a_tc !== (cur == 9)) begin
                errors++;
                $display("FAIL up_tc step=%0d tc=%0b expected %0b", i, a_tc, (cur == 9));
            end
            push_exp(8'(nxt), nxt == 0);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL up_wrap scoreboard empty");
            end else begin
                e = sb.pop_front();
                checks++;
                $display("up_wrap step=%0d q=%0d wrap=%0b", i, a_q, a_wrap);
                if (a_q !== e.q || a_wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL up_wrap step=%0d q=%0d wrap=%0b expected q=%0d wrap=%0b", i, a_q, a_wrap, e.q, e.wrap);
                end
            end
        end
        a_en = 1'b0;
    endtask

    task automatic test_down_wrap();
        exp_t e;
        int   q_t[4]  = '{1, 0, 9, 8};
        int   w_t[4]  = '{0, 0, 1, 0};
        int   tc_t[4] = '{0, 0, 1, 0};
        int   ld_t[4] = '{1, 0, 0, 0};
        a_up = 1'b0;
        a_lv = 8'd1;
        for (int i = 0; i < 4; i++) begin
            a_load = ld_t[i][0];
            a_en   = (ld_t[i] == 0);
            #1;
            checks++;
            if (a_tc !== tc_t[i][0]) begin
                errors++;
                $display("FAIL down_tc step=%0d tc=%0b expected %0b", i, a_tc, tc_t[i][0]);
            end
            push_exp(8'(q_t[i]), w_t[i][0]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL down_wrap scoreboard empty");
            end else begin
                e = sb.pop_front();
                checks++;
                $display("down_wrap step=%0d q=%0d wrap=%0b", i, a_q, a_wrap);
                if (a_q !== e.q || a_wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL down_wrap step=%0d q=%0d wrap=%0b expected q=%0d wrap=%0b", i, a_q, a_wrap, e.q, e.wrap);
                end
            end
        end
        a_load = 1'b0;
        a_en   = 1'b0;
    endtask

    // Starts at q=8: clr beats load, over-range load clamps, disabled hold, load beats count at top.
    task automatic test_priority_clamp();
        exp_t e;
        int   en_t[10]  = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        int   up_t[10]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        int   clr_t[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int   ld_t[10]  = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        int   lv_t[10]  = '{5, 12, 0, 0, 0, 0, 0, 4, 255, 10};
        int   q_t[10]   = '{0, 9, 9, 9, 9, 9, 9, 4, 9, 9};
        for (int i = 0; i < 10; i++) begin
            a_en   = en_t[i][0];
            a_up   = up_t[i][0];
            a_clr  = clr_t[i][0];
            a_load = ld_t[i][0];
            a_lv   = 8'(lv_t[i]);
            #1;
            checks++;
            if (a_tc !== 1'b0) begin
                errors++;
                $display("FAIL prio_tc step=%0d tc=%0b expected 0", i, a_tc);
            end
            push_exp(8'(q_t[i]), 1'b0);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL prio scoreboard empty");
            end else begin
                e = sb.pop_front();
                checks++;
                $display("prio step=%0d q=%0d wrap=%0b", i, a_q, a_wrap);
                if (a_q !== e.q || a_wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL prio step=%0d q=%0d wrap=%0b expected q=%0d wrap=%0b", i, a_q, a_wrap, e.q, e.wrap);
                end
            end
        end
        a_clr  = 1'b0;
        a_load = 1'b0;
        a_en   = 1'b0;
    endtask

    // From q=9: direction flips every cycle so wrap stays high on consecutive edges.
    task automatic test_back_to_back();
        exp_t e;
        int   up_t[5] = '{1, 0, 1, 1, 0};
        int   q_t[5]  = '{0, 9, 0, 1, 0};
        int   w_t[5]  = '{1, 1, 1, 0, 0};
        a_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_up = up_t[i][0];
            #1;
            checks++;
            if (a_tc !== w_t[i][0]) begin
                errors++;
                $display("FAIL b2b_tc step=%0d tc=%0b expected %0b", i, a_tc, w_t[i][0]);
            end
            push_exp(8'(q_t[i]), w_t[i][0]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b scoreboard empty");
            end else begin
                e = sb.pop_front();
                checks++;
                $display("b2b step=%0d q=%0d wrap=%0b", i, a_q, a_wrap);
                if (a_q !== e.q || a_wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL b2b step=%0d q=%0d wrap=%0b expected q=%0d wrap=%0b", i, a_q, a_wrap, e.q, e.wrap);
                end
            end
        end
        a_en = 1'b0;
    endtask

    // First row clears; en pause delays the step by 2 edges; loads restart the 4-cycle period.
    task automatic test_prescaler();
        exp_t e;
        int   clr_t[27] = '{1, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0};
        int   en_t[27]  = '{0, 1,1,1,1,1,1,1,1, 1,1,0,0,1,1, 1,1,1, 1,1,1,1, 1,1,1,1,1};
        int   ld_t[27]  = '{0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,1, 0,0,0,0, 1,0,0,0,0};
        int   lv_t[27]  = '{0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,7, 0,0,0,0, 9,0,0,0,0};
        int   q_t[27]   = '{0, 0,0,0,1,1,1,1,2, 2,2,2,2,2,3, 3,3,7, 7,7,7,8, 9,9,9,9,0};
        int   w_t[27]   = '{0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,1};
        p_up = 1'b1;
        for (int i = 0; i < 27; i++) begin
            p_clr  = clr_t[i][0];
            p_en   = en_t[i][0];
            p_load = ld_t[i][0];
            p_lv   = 8'(lv_t[i]);
            #1;
            checks++;
            if (p_tc !== w_t[i][0]) begin
                errors++;
                $display("FAIL presc_tc step=%0d tc=%0b expected %0b", i, p_tc, w_t[i][0]);
            end
            push_exp(8'(q_t[i]), w_t[i][0]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL presc scoreboard empty");
            end else begin
                e = sb.pop_front();
                checks++;
                $display("presc step=%0d q=%0d wrap=%0b", i, p_q, p_wrap);
                if (p_q !== e.q || p_wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL presc step=%0d q=%0d wrap=%0b expected q=%0d wrap=%0b", i, p_q, p_wrap, e.q, e.wrap);
                end
            end
        end
        p_en   = 1'b0;
        p_load = 1'b0;
        p_clr  = 1'b0;
    endtask

    // MODULUS == 2**WIDTH: wraps come from natural overflow/underflow.
    task automatic test_full_range();
        exp_t e;
        int   clr_t[6] = '{1, 0, 0, 0, 0, 0};
        int   en_t[6]  = '{0, 1, 1, 1, 0, 1};
        int   up_t[6]  = '{0, 0, 1, 1, 0, 1};
        int   ld_t[6]  = '{0, 0, 0, 0, 1, 0};
        int   q_t[6]   = '{0, 15, 0, 1, 15, 0};
        int   w_t[6]   = '{0, 1, 1, 0, 0, 1};
        f_lv = 4'd15;
        for (int i = 0; i < 6; i++) begin
            f_clr  = clr_t[i][0];
            f_en   = en_t[i][0];
            f_up   = up_t[i][0];
            f_load = ld_t[i][0];
            #1;
            checks++;
            if (f_tc !== w_t[i][0]) begin
                errors++;
                $display("FAIL full_tc step=%0d tc=%0b expected %0b", i, f_tc, w_t[i][0]);
            end
            push_exp(8'(q_t[i]), w_t[i][0]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL full scoreboard empty");
            end else begin
                e = sb.pop_front();
                checks++;
                $display("full step=%0d q=%0d wrap=%0b", i, f_q, f_wrap);
                if (f_q !== e.q[3:0] || f_wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL full step=%0d q=%0d wrap=%0b expected q=%0d wrap=%0b", i, f_q, f_wrap, e.q[3:0], e.wrap);
                end
            end
        end
        f_en   = 1'b0;
        f_load = 1'b0;
    endtask

    task automatic test_cascade();
        exp_t e;
        int   n;
        c_clr = 1'b1;
        push_exp(8'h00, 1'b0);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL cascade_clr scoreboard empty");
        end else begin
            e = sb.pop_front();
            checks++;
            if ({c1_q, c0_q} !== e.q || c1_wrap !== e.wrap) begin
                errors++;
                $display("FAIL cascade_clr q=%h wrap=%0b expected q=%h wrap=%0b", {c1_q, c0_q}, c1_wrap, e.q, e.wrap);
            end
        end
        c_clr = 1'b0;
        c_en  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n = i + 1;
            #1;
            checks++;
            if (c0_tc !== ((i % 10) == 9)) begin
                errors++;
                $display("FAIL cascade_tc step=%0d tc=%0b expected %0b", i, c0_tc, ((i % 10) == 9));
            end
            push_exp({4'((n / 10) % 10), 4'(n % 10)}, (n % 100) == 0);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL cascade scoreboard empty");
            end else begin
                e = sb.pop_front();
                checks++;
                $display("cascade edge=%0d q=%h wrap1=%0b", n, {c1_q, c0_q}, c1_wrap);
                if ({c1_q, c0_q} !== e.q || c1_wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL cascade edge=%0d q=%h wrap1=%0b expected q=%h wrap1=%0b", n, {c1_q, c0_q}, c1_wrap, e.q, e.wrap);
                end
            end
        end
        c_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_priority_clamp();
        test_back_to_back();
        test_prescaler();
        test_full_range();
        test_cascade();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog time=%0t expected completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
